// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map is indexed by {row, col}; a candidate is a hit flag plus the key code.
package keypad_pkg;

    typedef logic [1:0] col_phase_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } cand_t;

    // NONE keeps code at zero so whole-struct equality treats all misses alike.
    localparam cand_t CAND_NONE = '{hit: 1'b0, code: 4'h0};

    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic cand_t make_cand(logic [1:0] r, col_phase_t c);
        cand_t res;
        res.hit  = 1'b1;
        res.code = KEY_MAP[{r, c}];
        return res;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce and accept logic for the keypad scanner.
// Optional auto-repeat counter is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end,
    input  cand_t      cand,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_strobe
);

    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    cand_t         prev_q;
    cand_t         acc_q;
    logic [CW-1:0] stable_q;
    logic [CW-1:0] stable_d;
    logic          accept;

    always_comb begin
        stable_d = CW'(1);
        if (cand == prev_q) begin
            stable_d = (stable_q == CNT_MAX) ? CNT_MAX : stable_q + 1'b1;
        end
        accept = (stable_d == CNT_MAX) && (cand != acc_q);
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_q;
    logic          rep_armed_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= CAND_NONE;
            acc_q       <= CAND_NONE;
            stable_q    <= '0;
            key         <= 4'h0;
            key_valid   <= 1'b0;
            key_strobe  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            key_strobe <= 1'b0;
            if (frame_end) begin
                prev_q   <= cand;
                stable_q <= stable_d;
                if (accept) begin
                    acc_q <= cand;
                    if (cand.hit) begin
                        key        <= cand.code;
                        key_valid  <= 1'b1;
                        key_strobe <= 1'b1;
                    end else begin
                        key_valid  <= 1'b0;
                    end
                end
`ifdef KEYPAD_REPEAT_EN
                // First repeat after REPEAT_DELAY held frames, then every REPEAT_RATE.
                if (accept) begin
                    rep_q       <= '0;
                    rep_armed_q <= 1'b0;
                end else if (acc_q.hit && (cand == acc_q)) begin
                    if (!rep_armed_q && (rep_q == RW'(REPEAT_DELAY - 1))) begin
                        key_strobe  <= 1'b1;
                        rep_q       <= '0;
                        rep_armed_q <= 1'b1;
                    end else if (rep_armed_q && (rep_q == RW'(REPEAT_RATE - 1))) begin
                        key_strobe  <= 1'b1;
                        rep_q       <= '0;
                    end else begin
                        rep_q       <= rep_q + 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Pmod KYPD 4x4 scan controller: column drive, row sync, per-frame priority encode.
// Define KEYPAD_REPEAT_EN to enable auto-repeat strobes in the debounce stage.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_strobe
);

    localparam int unsigned TW = $clog2(SCAN_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

    if (SCAN_TICKS < 8) begin : g_bad_scan
        $error("SCAN_TICKS must be at least 8");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must be at least 1");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [TW-1:0] tick_q;
    col_phase_t    phase_q;
    cand_t         cand_q;
    logic          sample;
    logic          frame_end;
    logic [3:0]    rows_low;
    logic [1:0]    row_idx;
    cand_t         phase_cand;
    cand_t         frame_cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    always_comb begin
        sample    = (tick_q == TICK_LAST);
        frame_end = sample && (phase_q == 2'd3);
        rows_low  = ~row_sync;
        row_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows_low[i]) begin
                row_idx = 2'(i);
            end
        end
        phase_cand = (|rows_low) ? make_cand(row_idx, phase_q) : CAND_NONE;
        // An earlier column's hit in this frame keeps priority.
        frame_cand = cand_q.hit ? cand_q : phase_cand;
        col        = ~(4'b0001 << phase_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q  <= '0;
            phase_q <= '0;
            cand_q  <= CAND_NONE;
        end else if (sample) begin
            tick_q  <= '0;
            phase_q <= phase_q + 2'd1;
            cand_q  <= frame_end ? CAND_NONE : frame_cand;
        end else begin
            tick_q  <= tick_q + 1'b1;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_RATE   (REPEAT_RATE)
`endif
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .cand      (frame_cand),
        .key       (key),
        .key_valid (key_valid),
        .key_strobe(key_strobe)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-level reference model, directed
// scenarios plus randomized presses; honours KEYPAD_REPEAT_EN for the repeat scenario.
module tb_keypad_scanner;

    localparam int ST    = 8;
    localparam int DB    = 3;
    localparam int RD    = 5;
    localparam int RR    = 2;
    localparam int FRAME = 4 * ST;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_strobe;
    logic [15:0] pressed = '0;

    int checks  = 0;
    int errors  = 0;
    int nstrobe = 0;

    always #5 clk = ~clk;

    // Pressed switch at index r*4+c shorts row r to column c.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
        end
    end

    keypad_scanner #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid),
        .key_strobe(key_strobe)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    string keys = "123A456B789C0FED";

    function automatic int code_of(int idx);
        byte ch;
        ch = keys[idx];
        if (ch >= "A") return int'(ch) - 55;
        return int'(ch) - 48;
    endfunction

    // Reference model: m_k counts clock edges since reset release.
    int         m_k, m_fc, m_prev, m_stable, m_acc, m_held, hit_idx, cand, ph;
    logic [3:0] m_key, m_col;
    logic       m_valid, m_strobe, last_strobe;

    always @(negedge clk) begin
        if (rst) begin
            m_k = 0; m_fc = -1; m_prev = -1; m_stable = 0; m_acc = -1; m_held = 0;
            m_key = 4'h0; m_valid = 1'b0; m_strobe = 1'b0; m_col = 4'b1110;
        end else begin
            m_strobe = 1'b0;
            ph = (m_k / ST) % 4;
            if (m_k % ST == ST - 1) begin
                hit_idx = -1;
                for (int r = 3; r >= 0; r--) begin
                    if (pressed[r*4 + ph]) hit_idx = r * 4 + ph;
                end
                if (m_fc < 0) m_fc = hit_idx;
                if (ph == 3) begin
                    cand = (m_fc < 0) ? -1 : code_of(m_fc);
                    m_fc = -1;
                    if (cand == m_prev) m_stable = (m_stable < DB) ? m_stable + 1 : DB;
                    else m_stable = 1;
                    m_prev = cand;
                    if (m_stable == DB && cand != m_acc) begin
                        m_acc  = cand;
                        m_held = 0;
                        if (cand >= 0) begin
                            m_key = 4'(cand); m_valid = 1'b1; m_strobe = 1'b1;
                        end else begin
                            m_valid = 1'b0;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (m_acc >= 0 && cand == m_acc) begin
                        m_held++;
                        if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0))
                            m_strobe = 1'b1;
                    end
`endif
                end
            end
            m_k++;
            m_col = ~(4'b0001 << ((m_k / ST) % 4));
        end
        check("col", col, m_col);
        check("key", key, m_key);
        check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        check("key_strobe", {3'b0, key_strobe}, {3'b0, m_strobe});
        check("strobe_back_to_back", {3'b0, key_strobe & last_strobe}, 4'h0);
        last_strobe = key_strobe;
        if (key_strobe === 1'b1) nstrobe++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic safe_point();
        tick(1);
        while (((m_k - 1) % ST) > 3) tick(1);
    endtask

    int          base;
    logic [15:0] one = 16'h0001;

    initial begin
        rst = 1'b1;
        tick(3);
        check("rst_col", col, 4'b1110);
        check("rst_key", key, 4'h0);
        check("rst_valid", {3'b0, key_valid}, 4'h0);
        check("rst_strobe", {3'b0, key_strobe}, 4'h0);
        rst = 1'b0;

        tick(1); check("scan_c0", col, 4'b1110);
        tick(8); check("scan_c1", col, 4'b1101);
        tick(8); check("scan_c2", col, 4'b1011);
        tick(8); check("scan_c3", col, 4'b0111);
        tick(8); check("scan_wrap", col, 4'b1110);

        // Key 6 at row 1 / column 2, pressed at a frame start.
        base = nstrobe;
        pressed = one << 6;
        tick(3 * FRAME);
        check("k6_strobes", 4'(nstrobe - base), 4'd1);
        check("k6_key", key, 4'h6);
        check("k6_valid", {3'b0, key_valid}, 4'h1);
        pressed = '0;
        tick(2 * FRAME);
        check("k6_still_valid", {3'b0, key_valid}, 4'h1);
        tick(FRAME);
        check("k6_released", {3'b0, key_valid}, 4'h0);
        check("k6_key_held", key, 4'h6);

        // Alternate-frame bounce on key 1 never reaches three stable frames.
        base = nstrobe;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? one : 16'h0000;
            tick(FRAME);
        end
        check("bounce_no_strobe", 4'(nstrobe - base), 4'd0);
        pressed = one;
        tick(2 * FRAME);
        check("bounce_two_frames", 4'(nstrobe - base), 4'd0);
        tick(FRAME);
        check("bounce_accept", 4'(nstrobe - base), 4'd1);
        check("bounce_key", key, 4'h1);

        // Keys 5 and D together: 5 wins by column order; D follows on release of 5.
        pressed = '0;
        tick(4 * FRAME);
        base = nstrobe;
        pressed = (one << 5) | (one << 15);
        tick(3 * FRAME);
        check("multi_key5", key, 4'h5);
        check("multi_strobe1", 4'(nstrobe - base), 4'd1);
        pressed = one << 15;
        tick(3 * FRAME);
        check("multi_keyD", key, 4'hD);
        check("multi_strobe2", 4'(nstrobe - base), 4'd2);
        check("multi_valid", {3'b0, key_valid}, 4'h1);

        // Reset in the frame after acceptance of C, key still held.
        pressed = '0;
        tick(4 * FRAME);
        pressed = one << 11;
        tick(3 * FRAME);
        check("pre_rst_key", key, 4'hC);
        tick(10);
        rst = 1'b1;
        tick(2);
        check("midrst_col", col, 4'b1110);
        check("midrst_key", key, 4'h0);
        check("midrst_valid", {3'b0, key_valid}, 4'h0);
        base = nstrobe;
        rst = 1'b0;
        tick(1 + 3 * FRAME);
        check("reaccept_strobe", 4'(nstrobe - base), 4'd1);
        check("reaccept_key", key, 4'hC);

        // Hold 9 for 12 frames.
        pressed = '0;
        tick(4 * FRAME);
        base = nstrobe;
        pressed = one << 10;
        tick(12 * FRAME);
        check("hold9_key", key, 4'h9);
`ifdef KEYPAD_REPEAT_EN
        check("hold9_strobes", 4'(nstrobe - base), 4'd4);
`else
        check("hold9_strobes", 4'(nstrobe - base), 4'd1);
`endif

        // Randomized presses with mid-frame changes and occasional resets.
        repeat (40) begin
            tick($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
            safe_point();
            case ($urandom_range(0, 9))
                0, 1, 2: pressed = '0;
                3, 4, 5, 6, 7: pressed = one << $urandom_range(0, 15);
                default: pressed = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            endcase
            tick($urandom_range(1, 5) * FRAME);
            safe_point();
        end
        pressed = '0;
        tick(4 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
